// File: rtl/e_mdu_if.sv
// E-stage multiply/divide unit bus: issue controls and operands toward the MDU,
// status and HI/LO read-back toward the pipeline.
interface e_mdu_if;
  logic        start;
  logic [3:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDUOut;
  logic        MDUStallReq;

  modport master (
    output start, MDUOp, A, B,
    input  busy, HI, LO, MDUOut, MDUStallReq
  );

  modport slave (
    input  start, MDUOp, A, B,
    output busy, HI, LO, MDUOut, MDUStallReq
  );
endinterface

// File: rtl/e_mdu.sv
// Multi-cycle MIPS multiply/divide unit: computes the 64-bit result at issue, holds it
// pending for a fixed busy period, then commits it to the architectural HI/LO.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic   clk,
  input  logic   reset,
  e_mdu_if.slave bus
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  function automatic logic [63:0] mul_signed(input logic signed [31:0] a,
                                             input logic signed [31:0] b);
    logic signed [63:0] ax;
    logic signed [63:0] bx;
    logic signed [63:0] p;
    ax = a;
    bx = b;
    p  = ax * bx;
    return p;
  endfunction

  function automatic logic [63:0] mul_unsigned(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax;
    logic [63:0] bx;
    ax = {32'd0, a};
    bx = {32'd0, b};
    return ax * bx;
  endfunction

  // Signed divide via magnitudes so the most-negative / -1 case wraps instead of trapping;
  // quotient truncates toward zero, remainder takes the dividend's sign. Returns {rem, quo}.
  function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] q;
    logic [31:0] r;
    ma = a[31] ? (~a + 32'd1) : a;
    mb = b[31] ? (~b + 32'd1) : b;
    q  = ma / mb;
    r  = ma % mb;
    if (a[31] ^ b[31]) q = ~q + 32'd1;
    if (a[31])         r = ~r + 32'd1;
    return {r, q};
  endfunction

  function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
    return {a % b, a / b};
  endfunction

  logic [CNT_W-1:0] cnt;
  logic             busy_w;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [31:0]      phi_p1;
  logic [31:0]      plo_p1;
  logic             pwr_p1;
  logic             is_mul;
  logic             is_arith;
  logic [63:0]      res_p0;

  assign busy_w   = (cnt != '0);
  assign is_mul   = (bus.MDUOp == OP_MULT) || (bus.MDUOp == OP_MULTU);
  assign is_arith = is_mul || (bus.MDUOp == OP_DIV) || (bus.MDUOp == OP_DIVU);

  always_comb begin
    res_p0 = '0;
    case (bus.MDUOp)
      OP_MULT:  res_p0 = mul_signed(bus.A, bus.B);
      OP_MULTU: res_p0 = mul_unsigned(bus.A, bus.B);
      OP_DIV:   res_p0 = div_signed(bus.A, bus.B);
      OP_DIVU:  res_p0 = div_unsigned(bus.A, bus.B);
      default:  res_p0 = '0;
    endcase
  end

  // p0 -> p1: result captured at issue, committed to HI/LO as the counter expires
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      phi_p1 <= '0;
      plo_p1 <= '0;
      pwr_p1 <= 1'b0;
    end else if (busy_w) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1) && pwr_p1) begin
        hi_q <= phi_p1;
        lo_q <= plo_p1;
      end
    end else if (bus.start && is_arith) begin
      cnt              <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      {phi_p1, plo_p1} <= res_p0;
      // a zero divisor still runs the full period but leaves HI/LO untouched
      pwr_p1           <= is_mul || (bus.B != 32'd0);
    end else if (!bus.start) begin
      if (bus.MDUOp == OP_MTHI) hi_q <= bus.A;
      if (bus.MDUOp == OP_MTLO) lo_q <= bus.A;
    end
  end

  assign bus.busy        = busy_w;
  assign bus.HI          = hi_q;
  assign bus.LO          = lo_q;
  assign bus.MDUStallReq = bus.start | busy_w;
  assign bus.MDUOut      = (bus.MDUOp == OP_MFHI) ? hi_q :
                           (bus.MDUOp == OP_MFLO) ? lo_q : 32'd0;
endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed cases plus randomized ops against an
// arithmetic reference model of HI/LO.
module tb_e_mdu;
  logic clk = 1'b0;
  logic reset;
  e_mdu_if bus();

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0;
    bus.MDUOp = 4'd0;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
  endtask

  // Reference: architectural result of an op straight from the ISA definition.
  task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sp, q, r;
    longint unsigned up;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    case (op)
      4'd1: begin sp = sa * sb; {m_hi, m_lo} = sp; end
      4'd2: begin up = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = up; end
      4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      4'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      default: ;
    endcase
  endtask

  function automatic int exp_cycles(input logic [3:0] op);
    return (op <= 4'd2) ? 5 : 10;
  endfunction

  // Issue one op and measure its busy period (bounded); leaves the bench in the first
  // cycle after busy falls.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int nbusy, output int nstall);
    bus.start = 1'b1; bus.MDUOp = op; bus.A = a; bus.B = b;
    #1;
    nstall = bus.MDUStallReq ? 1 : 0;
    cyc();
    idle_inputs();
    nbusy = 0;
    while (bus.busy === 1'b1 && nbusy < 50) begin
      nbusy++;
      if (bus.MDUStallReq === 1'b1) nstall++;
      cyc();
    end
  endtask

  task automatic do_mt(input logic [3:0] op, input logic [31:0] v);
    bus.start = 1'b0; bus.MDUOp = op; bus.A = v;
    cyc();
    idle_inputs();
    if (op == 4'd5) m_hi = v; else m_lo = v;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    cyc(); cyc(); cyc();
    m_hi = 0; m_lo = 0;
    n_checks++; if (bus.HI !== 32'd0) begin n_fail++; $display("FAIL reset_hi got=%h exp=0", bus.HI); end
    n_checks++; if (bus.LO !== 32'd0) begin n_fail++; $display("FAIL reset_lo got=%h exp=0", bus.LO); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_checks++; if (bus.MDUOut !== 32'd0) begin n_fail++; $display("FAIL reset_mduout got=%h exp=0", bus.MDUOut); end
    n_checks++; if (bus.MDUStallReq !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", bus.MDUStallReq); end
  endtask

  task automatic test_mult();
    int nb, ns;
    do_op(4'd1, 32'hFFFF_FFFF, 32'h0000_0002, nb, ns);
    model_apply(4'd1, 32'hFFFF_FFFF, 32'h0000_0002);
    n_checks++; if (nb != 5) begin n_fail++; $display("FAIL mult_busy got=%0d exp=5", nb); end
    n_checks++; if (ns != 6) begin n_fail++; $display("FAIL mult_stall got=%0d exp=6", ns); end
    n_checks++; if ({bus.HI, bus.LO} !== 64'hFFFF_FFFF_FFFF_FFFE)
      begin n_fail++; $display("FAIL mult_hilo got=%h_%h exp=ffffffff_fffffffe", bus.HI, bus.LO); end
    do_op(4'd2, 32'hFFFF_FFFF, 32'h0000_0002, nb, ns);
    model_apply(4'd2, 32'hFFFF_FFFF, 32'h0000_0002);
    n_checks++; if (nb != 5) begin n_fail++; $display("FAIL multu_busy got=%0d exp=5", nb); end
    n_checks++; if ({bus.HI, bus.LO} !== 64'h0000_0001_FFFF_FFFE)
      begin n_fail++; $display("FAIL multu_hilo got=%h_%h exp=00000001_fffffffe", bus.HI, bus.LO); end
  endtask

  task automatic test_div();
    int nb, ns;
    do_op(4'd3, 32'hFFFF_FFF9, 32'd2, nb, ns);
    model_apply(4'd3, 32'hFFFF_FFF9, 32'd2);
    n_checks++; if (nb != 10) begin n_fail++; $display("FAIL div_busy got=%0d exp=10", nb); end
    n_checks++; if ({bus.HI, bus.LO} !== 64'hFFFF_FFFF_FFFF_FFFD)
      begin n_fail++; $display("FAIL div_hilo got=%h_%h exp=ffffffff_fffffffd", bus.HI, bus.LO); end
    do_op(4'd4, 32'hFFFF_FFF9, 32'd2, nb, ns);
    model_apply(4'd4, 32'hFFFF_FFF9, 32'd2);
    n_checks++; if (nb != 10) begin n_fail++; $display("FAIL divu_busy got=%0d exp=10", nb); end
    n_checks++; if ({bus.HI, bus.LO} !== 64'h0000_0001_7FFF_FFFC)
      begin n_fail++; $display("FAIL divu_hilo got=%h_%h exp=00000001_7ffffffc", bus.HI, bus.LO); end
  endtask

  task automatic test_div_zero();
    int nb, ns;
    do_mt(4'd5, 32'h0000_1234);
    n_checks++; if (bus.HI !== 32'h1234) begin n_fail++; $display("FAIL mthi got=%h exp=00001234", bus.HI); end
    do_mt(4'd6, 32'h0000_5678);
    n_checks++; if (bus.LO !== 32'h5678) begin n_fail++; $display("FAIL mtlo got=%h exp=00005678", bus.LO); end
    do_op(4'd3, 32'h0000_0064, 32'd0, nb, ns);
    n_checks++; if (nb != 10) begin n_fail++; $display("FAIL divz_busy got=%0d exp=10", nb); end
    n_checks++; if ({bus.HI, bus.LO} !== 64'h0000_1234_0000_5678)
      begin n_fail++; $display("FAIL divz_hilo got=%h_%h exp=00001234_00005678", bus.HI, bus.LO); end
    bus.MDUOp = 4'd7; #1;
    n_checks++; if (bus.MDUOut !== 32'h1234) begin n_fail++; $display("FAIL mfhi got=%h exp=00001234", bus.MDUOut); end
    bus.MDUOp = 4'd8; #1;
    n_checks++; if (bus.MDUOut !== 32'h5678) begin n_fail++; $display("FAIL mflo got=%h exp=00005678", bus.MDUOut); end
    bus.MDUOp = 4'd9; #1;
    n_checks++; if (bus.MDUOut !== 32'd0) begin n_fail++; $display("FAIL mdu_out_other got=%h exp=0", bus.MDUOut); end
    idle_inputs();
  endtask

  task automatic test_conflict();
    int n;
    bus.start = 1'b1; bus.MDUOp = 4'd1; bus.A = 32'd3; bus.B = 32'd4;
    cyc();
    idle_inputs();
    n = 0;
    while (bus.busy === 1'b1 && n < 50) begin
      n++;
      if (n == 2) begin bus.start = 1'b1; bus.MDUOp = 4'd4; bus.A = 32'd100; bus.B = 32'd7; end
      else if (n == 3) begin bus.start = 1'b0; bus.MDUOp = 4'd6; bus.A = 32'hDEAD; end
      else idle_inputs();
      cyc();
    end
    idle_inputs();
    m_hi = 32'd0; m_lo = 32'd12;
    n_checks++; if (n != 5) begin n_fail++; $display("FAIL conflict_busy got=%0d exp=5", n); end
    n_checks++; if ({bus.HI, bus.LO} !== {m_hi, m_lo})
      begin n_fail++; $display("FAIL conflict_hilo got=%h_%h exp=%h_%h", bus.HI, bus.LO, m_hi, m_lo); end
    cyc();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL conflict_nostart got=%b exp=0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_mt(4'd5, 32'h0000_00AA);
    bus.start = 1'b1; bus.MDUOp = 4'd1; bus.A = 32'd3; bus.B = 32'd4;
    cyc();
    idle_inputs();
    n = 0;
    while (bus.busy === 1'b1 && n < 3) begin
      n++;
      if (n == 3) reset = 1'b1;
      cyc();
    end
    reset = 1'b0;
    m_hi = 0; m_lo = 0;
    n_checks++; if (n != 3) begin n_fail++; $display("FAIL rstmid_reach got=%0d exp=3", n); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
    n_checks++; if ({bus.HI, bus.LO} !== 64'd0)
      begin n_fail++; $display("FAIL rstmid_hilo got=%h_%h exp=0_0", bus.HI, bus.LO); end
    repeat (12) cyc();
    n_checks++; if ({bus.HI, bus.LO} !== 64'd0)
      begin n_fail++; $display("FAIL rstmid_late got=%h_%h exp=0_0", bus.HI, bus.LO); end
  endtask

  task automatic test_random();
    int nb, ns, kind;
    logic [31:0] a, b;
    logic [3:0] op;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 5);
      a = rand_operand();
      b = rand_operand();
      if (kind < 4) begin
        op = 4'(kind + 1);
        do_op(op, a, b, nb, ns);
        model_apply(op, a, b);
        n_checks++; if (nb != exp_cycles(op))
          begin n_fail++; $display("FAIL rand_busy op=%0d got=%0d exp=%0d", op, nb, exp_cycles(op)); end
      end else begin
        op = (kind == 4) ? 4'd5 : 4'd6;
        do_mt(op, a);
      end
      n_checks++; if ({bus.HI, bus.LO} !== {m_hi, m_lo})
        begin n_fail++; $display("FAIL rand_hilo op=%0d a=%h b=%h got=%h_%h exp=%h_%h",
                                 op, a, b, bus.HI, bus.LO, m_hi, m_lo); end
    end
    bus.MDUOp = 4'd8; #1;
    n_checks++; if (bus.MDUOut !== m_lo) begin n_fail++; $display("FAIL rand_mflo got=%h exp=%h", bus.MDUOut, m_lo); end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_conflict();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multi-cycle multiply/divide unit in the E stage of the 5-stage MIPS pipeline, alongside the ALU.
- Executes mult/multu/div/divu with fixed latencies and holds the architectural HI/LO registers.
- Services mthi/mtlo writes and mfhi/mflo reads.
- Exports busy/start status so the stall unit can freeze any MDU-class instruction in D while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu.
- DIV_CYCLES, 10, busy cycles for div/divu.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset; clears HI, LO, busy, counter
- start  input  1  one-cycle pulse; E-stage instruction is mult/multu/div/divu this cycle
- MDUOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; others treated as none
- A  input  32  forwarded rs value (FE_RD1)
- B  input  32  forwarded rt value (FE_RD2)
- busy  output  1  operation in flight
- HI  output  32  architectural HI
- LO  output  32  architectural LO
- MDUOut  output  32  combinational: HI when MDUOp=7, LO when MDUOp=8, else 0
- MDUStallReq  output  1  combinational start|busy, consumed by the stall unit

Behaviour:
- Reset: on a clk edge with reset=1, HI=0, LO=0, busy=0, counter=0, pending result cleared. Reset has priority over every other input, including mid-operation; an in-flight operation is aborted and its result is never written.
- Idle (busy=0), start=1 with MDUOp 1-4, edge T:
  - A and B are consumed at edge T and the 64-bit result is latched into a pending register {pHI,pLO}.
  - Counter loads MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
  - busy=1 from the cycle after edge T.
- Busy: counter decrements each edge. On the edge where counter goes 1->0:
  - busy drops to 0.
  - HI<=pHI and LO<=pLO on that same edge.
  - busy is high for exactly N cycles; new HI/LO are visible in the first cycle after busy falls.
- Arithmetic:
  - mult: signed 32x32->64, {HI,LO}=product.
  - multu: unsigned 32x32->64, {HI,LO}=product.
  - div: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - divu: unsigned; LO=quotient; HI=remainder.
  - Divide by zero (B=0): full DIV_CYCLES busy period still occurs; HI and LO remain unchanged at completion.
- mthi/mtlo: when busy=0 and start=0, MDUOp=5 writes HI<=A on the edge; MDUOp=6 writes LO<=A on the edge. No busy is generated.
- mfhi/mflo: purely combinational reads of the current HI/LO. A value written by mthi/mtlo at an edge is readable in the following cycle.
- Conflicts (the stall unit prevents these; behaviour is fixed regardless):
  - start=1 while busy=1 is ignored; the current operation continues.
  - mthi/mtlo while busy=1 is ignored.
  - start=1 with MDUOp outside 1-4 is ignored.
- MDUStallReq is high in the start cycle and in every busy cycle. An MDU-class instruction in D stalls until both start and busy are 0.
- A bubble inserted into E (E_REG cleared) presents MDUOp=0 and start=0; no state change results.

Test Plan:
- Reset, then idle 3 cycles -> HI=0, LO=0, busy=0, MDUOut=0, MDUStallReq=0.
- start, mult, A=0xFFFFFFFF (-1), B=0x00000002 -> busy high exactly 5 cycles starting the cycle after start; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFE. Same operands with multu -> HI=0x00000001, LO=0xFFFFFFFE.
- start, div, A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Same operands with divu -> LO=0x7FFFFFFC, HI=0x00000001.
- Preload with mthi A=0x1234, then mtlo A=0x5678; then div B=0 -> busy 10 cycles; HI=0x1234 and LO=0x5678 unchanged. Then MDUOp=7 -> MDUOut=0x1234.
- mult 3x4 starts; at busy cycle 2, assert start with divu and mtlo A=0xDEAD in turn -> both ignored; after completion HI=0, LO=12.
- mult 3x4 starts; assert reset at busy cycle 3 -> next cycle busy=0, HI=0, LO=0; no later write occurs.
